// File: rtl/text_pixel_renderer_pkg.sv
// Shared constants and helpers for the text pixel renderer: active-area defaults,
// pipeline depth, RGB565 colours and the font ROM address layout.
package text_pixel_pkg;

  localparam int H_ACTIVE_DEFAULT = 1280;
  localparam int V_ACTIVE_DEFAULT = 720;
  localparam int PIPE_DEPTH       = 3;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

  localparam int ASCII_W     = 7;
  localparam int ROW_W       = 3;
  localparam int FONT_ADDR_W = ASCII_W + ROW_W;

  // Per-pixel flags that travel alongside the font fetch.
  typedef struct packed {
    logic active;
    logic cursor;
    logic textEnable;
    logic inverse;
  } pipe_flags_t;

  function automatic logic [FONT_ADDR_W-1:0] fontAddr(input logic [7:0] ch,
                                                      input logic [ROW_W-1:0] row);
    return {ch[ASCII_W-1:0], row};
  endfunction

endpackage

// File: rtl/text_pixel_renderer_if.sv
// Character ROM bus: registered address out, font row back one cycle later.
interface text_pixel_renderer_if;
  import text_pixel_pkg::*;

  logic [FONT_ADDR_W-1:0] fontRomAddress;
  logic [7:0]             fontRomData;

  modport master (output fontRomAddress, input fontRomData);
  modport slave  (input fontRomAddress, output fontRomData);
endinterface

// File: rtl/text_cursor_blinker.sv
// Cursor blink phase generator: toggles every CURSOR_BLINK_FRAMES frame pulses;
// a period of 0 leaves the phase permanently on.
module text_cursor_blinker #(
  parameter int CURSOR_BLINK_FRAMES = 30
) (
  input  logic clock,
  input  logic reset,
  input  logic newScreen,
  output logic blinkPhase
);

  localparam int CNT_W = (CURSOR_BLINK_FRAMES > 1) ? $clog2(CURSOR_BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_FRAME =
    CNT_W'((CURSOR_BLINK_FRAMES > 0) ? CURSOR_BLINK_FRAMES - 1 : 0);

  logic [CNT_W-1:0] frameCnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      frameCnt   <= '0;
      blinkPhase <= 1'b1;
    end else if ((CURSOR_BLINK_FRAMES != 0) && newScreen) begin
      if (frameCnt == LAST_FRAME) begin
        frameCnt   <= '0;
        blinkPhase <= ~blinkPhase;
      end else begin
        frameCnt <= frameCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_pixel_renderer.sv
// Text-mode pixel renderer: font row fetch, bit select, inverse video, blinking
// cursor and frame-synchronous colours, producing RGB565 with a fixed 3-cycle latency.
module text_pixel_renderer
  import text_pixel_pkg::*;
#(
  parameter int          H_ACTIVE            = H_ACTIVE_DEFAULT,
  parameter int          V_ACTIVE            = V_ACTIVE_DEFAULT,
  parameter int          CURSOR_BLINK_FRAMES = 30,
  parameter logic [15:0] RESET_FG            = WHITE,
  parameter logic [15:0] RESET_BG            = BLACK
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [10:0]                   pixelIndex,
  input  logic [9:0]                    lineIndex,
  input  logic                          newScreen,
  input  logic                          textEnable,
  input  logic [7:0]                    textRamData,
  input  logic [ROW_W-1:0]              asciiLineIndex,
  input  logic [2:0]                    asciiBitSelector,
  input  logic                          cursorVisible,
  input  logic [15:0]                   foreGroundColor,
  input  logic [15:0]                   backGroundColor,
  text_pixel_renderer_if.master         fontRom,
  output logic [15:0]                   pixelColor,
  output logic                          pixelValid
);

  logic                   active0;
  logic                   blinkPhase;
  logic                   fgSel;
  logic [FONT_ADDR_W-1:0] fontRomAddressReg;
  logic [15:0]            fgReg;
  logic [15:0]            bgReg;
  logic [15:0]            nextColor;
  pipe_flags_t            flags1;
  pipe_flags_t            flags2;

  assign active0 = (int'(pixelIndex) < H_ACTIVE) && (int'(lineIndex) < V_ACTIVE);
  assign fontRom.fontRomAddress = fontRomAddressReg;

  // fontRomData arrives for the pixel now held in flags2; bit 7 is the leftmost column.
  assign fgSel = fontRom.fontRomData[asciiBitSelector] ^ flags2.inverse;

  text_cursor_blinker #(
    .CURSOR_BLINK_FRAMES(CURSOR_BLINK_FRAMES)
  ) u_blinker (
    .clock      (clock),
    .reset      (reset),
    .newScreen  (newScreen),
    .blinkPhase (blinkPhase)
  );

  always_comb begin
    nextColor = BLACK;
    if (!flags2.active) begin
      nextColor = BLACK;
    end else if (!flags2.textEnable) begin
      nextColor = bgReg;
    end else if (flags2.cursor && blinkPhase) begin
      nextColor = flags2.inverse ? bgReg : fgReg;
    end else begin
      nextColor = fgSel ? fgReg : bgReg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fontRomAddressReg <= '0;
      flags1            <= '0;
      flags2            <= '0;
      pixelColor        <= BLACK;
      pixelValid        <= 1'b0;
      fgReg             <= RESET_FG;
      bgReg             <= RESET_BG;
    end else begin
      fontRomAddressReg <= fontAddr(textRamData, asciiLineIndex);
      flags1            <= '{active: active0, cursor: cursorVisible,
                             textEnable: textEnable, inverse: textRamData[7]};
      flags2            <= flags1;
      pixelColor        <= nextColor;
      pixelValid        <= flags2.active;
      // Colours only change at frame start so a frame never tears.
      if (newScreen) begin
        fgReg <= foreGroundColor;
        bgReg <= backGroundColor;
      end
    end
  end

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Directed bench for text_pixel_renderer: a history-based frame/pixel model checks
// every cycle, and hand-computed literals pin the key scenarios.
module tb_text_pixel_renderer;

  localparam int HIST = 1024;
  localparam logic [15:0] R_FG = 16'hFFFF;
  localparam logic [15:0] R_BG = 16'h0000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic [10:0] pixelIndex = 11'd2047;
  logic [9:0]  lineIndex = 10'd0;
  logic        newScreen = 1'b0;
  logic        textEnable = 1'b1;
  logic [7:0]  textRamData = 8'h00;
  logic [2:0]  asciiLineIndex = 3'd0;
  logic [2:0]  asciiBitSelector = 3'd0;
  logic        cursorVisible = 1'b0;
  logic [15:0] foreGroundColor = 16'hFFFF;
  logic [15:0] backGroundColor = 16'h0000;

  logic [15:0] pixelColor, pixelColor0;
  logic        pixelValid, pixelValid0;

  text_pixel_renderer_if fontRom ();
  text_pixel_renderer_if fontRom0 ();

  text_pixel_renderer #(.CURSOR_BLINK_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .pixelIndex(pixelIndex), .lineIndex(lineIndex),
    .newScreen(newScreen), .textEnable(textEnable), .textRamData(textRamData),
    .asciiLineIndex(asciiLineIndex), .asciiBitSelector(asciiBitSelector),
    .cursorVisible(cursorVisible), .foreGroundColor(foreGroundColor),
    .backGroundColor(backGroundColor), .fontRom(fontRom),
    .pixelColor(pixelColor), .pixelValid(pixelValid)
  );

  text_pixel_renderer #(.CURSOR_BLINK_FRAMES(0)) dut0 (
    .clock(clock), .reset(reset), .pixelIndex(pixelIndex), .lineIndex(lineIndex),
    .newScreen(newScreen), .textEnable(textEnable), .textRamData(textRamData),
    .asciiLineIndex(asciiLineIndex), .asciiBitSelector(asciiBitSelector),
    .cursorVisible(cursorVisible), .foreGroundColor(foreGroundColor),
    .backGroundColor(backGroundColor), .fontRom(fontRom0),
    .pixelColor(pixelColor0), .pixelValid(pixelValid0)
  );

  // ---------------- font ROM model ----------------
  function automatic logic [7:0] font_fn(input logic [9:0] a);
    if (a == 10'h20B) return 8'h80;
    if (a == 10'h000) return 8'h00;
    return a[7:0] ^ {a[9:8], a[9:4]} ^ 8'h5A;
  endfunction

  always @(posedge clock) begin
    fontRom.fontRomData  <= font_fn(fontRom.fontRomAddress);
    fontRom0.fontRomData <= font_fn(fontRom0.fontRomAddress);
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic [10:0] h_px  [HIST];
  logic [9:0]  h_ln  [HIST];
  logic [7:0]  h_ram [HIST];
  logic [2:0]  h_row [HIST];
  logic [2:0]  h_sel [HIST];
  logic [15:0] h_fg  [HIST];
  logic [15:0] h_bg  [HIST];
  logic        h_te  [HIST];
  logic        h_cur [HIST];
  logic        h_ns  [HIST];
  logic        h_rst [HIST];

  function automatic bit reset_seen(input int a, input int b);
    for (int j = a; j <= b; j++) if (j < 0 || h_rst[j]) return 1'b1;
    return 1'b0;
  endfunction

  // Colour in effect during cycle k: latest reset or frame-pulse load before it.
  function automatic logic [15:0] colour_at(input int k, input bit fg);
    for (int j = k - 1; j >= 0; j--) begin
      if (h_rst[j]) return fg ? R_FG : R_BG;
      if (h_ns[j])  return fg ? h_fg[j] : h_bg[j];
    end
    return fg ? R_FG : R_BG;
  endfunction

  // Cursor shown iff the number of completed frames since reset lies in an even half-period.
  function automatic bit blink_at(input int k, input int n);
    int  frames = 0;
    bit  stop = 0;
    for (int j = k - 1; j >= 0; j--) begin
      if (!stop) begin
        if (h_rst[j]) stop = 1;
        else if (h_ns[j]) frames++;
      end
    end
    if (n == 0) return 1'b1;
    return ((frames / n) % 2) == 0;
  endfunction

  function automatic logic [16:0] expect_pixel(input int c, input int n);
    int p;
    logic [15:0] fg, bg;
    logic [7:0] font;
    logic inv, fbit;
    if (reset_seen(c - 3, c - 1)) return 17'h0;
    p = c - 3;
    if (!(h_px[p] < 11'd1280 && h_ln[p] < 10'd720)) return 17'h0;
    fg   = colour_at(c - 1, 1'b1);
    bg   = colour_at(c - 1, 1'b0);
    inv  = h_ram[p][7];
    font = font_fn({h_ram[p][6:0], h_row[p]});
    fbit = font[h_sel[c - 1]];
    if (!h_te[p]) return {1'b1, bg};
    if (h_cur[p] && blink_at(c - 1, n)) return {1'b1, inv ? bg : fg};
    return {1'b1, (fbit ^ inv) ? fg : bg};
  endfunction

  function automatic logic [9:0] expect_addr(input int c);
    if (reset_seen(c - 1, c - 1)) return 10'h0;
    return {h_ram[c - 1][6:0], h_row[c - 1]};
  endfunction

  always @(negedge clock) begin
    if (cyc < HIST) begin
      h_px[cyc]  = pixelIndex;      h_ln[cyc]  = lineIndex;
      h_ram[cyc] = textRamData;     h_row[cyc] = asciiLineIndex;
      h_sel[cyc] = asciiBitSelector; h_te[cyc] = textEnable;
      h_cur[cyc] = cursorVisible;   h_ns[cyc]  = newScreen;
      h_rst[cyc] = reset;           h_fg[cyc]  = foreGroundColor;
      h_bg[cyc]  = backGroundColor;
      check("model_addr",   {22'b0, fontRom.fontRomAddress},  {22'b0, expect_addr(cyc)});
      check("model_addr0",  {22'b0, fontRom0.fontRomAddress}, {22'b0, expect_addr(cyc)});
      check("model_pixel",  {15'b0, pixelValid, pixelColor},   {15'b0, expect_pixel(cyc, 2)});
      check("model_pixel0", {15'b0, pixelValid0, pixelColor0}, {15'b0, expect_pixel(cyc, 0)});
    end
    cyc <= cyc + 1;
  end

  // ---------------- driver tasks ----------------
  logic [2:0] sel_q0 = 3'd0, sel_q1 = 3'd0;

  // Drives one cycle; the bit selector for a pixel follows it two cycles later.
  task automatic step(input logic [10:0] px, input logic [9:0] ln, input logic [7:0] ram,
                      input logic [2:0] row, input logic [2:0] sel, input logic cur,
                      input logic te, input logic ns, input logic rst);
    @(posedge clock); #1;
    pixelIndex = px; lineIndex = ln; textRamData = ram; asciiLineIndex = row;
    cursorVisible = cur; textEnable = te; newScreen = ns; reset = rst;
    asciiBitSelector = sel_q1;
    sel_q1 = sel_q0;
    sel_q0 = sel;
  endtask

  task automatic idle(input logic ns);
    step(11'd2047, 10'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1, ns, 1'b0);
  endtask

  task automatic pix(input string name, input logic [10:0] px, input logic [9:0] ln,
                     input logic [7:0] ram, input logic [2:0] row, input logic [2:0] sel,
                     input logic cur, input logic te,
                     input logic [15:0] exp_color, input logic exp_valid);
    step(px, ln, ram, row, sel, cur, te, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);
    @(negedge clock);
    check({name, "_color"}, {16'b0, pixelColor}, {16'b0, exp_color});
    check({name, "_valid"}, {31'b0, pixelValid}, {31'b0, exp_valid});
  endtask

  logic [15:0] blink_exp [6] = '{16'hFFFF, 16'hFFFF, 16'h07E0, 16'h07E0, 16'hFFFF, 16'hFFFF};

  initial begin
    step(11'd0, 10'd0, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 1'b1, 1'b1);
    step(11'd0, 10'd0, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clock);
    check("reset_color", {16'b0, pixelColor}, 32'h0);
    check("reset_valid", {31'b0, pixelValid}, 32'h0);
    check("reset_addr",  {22'b0, fontRom.fontRomAddress}, 32'h0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // Basic glyph pixel 'A', row 3, leftmost column
    step(11'd0, 10'd0, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clock);
    check("addr_41_row3", {22'b0, fontRom.fontRomAddress}, 32'h20B);
    idle(1'b0); idle(1'b0);
    @(negedge clock);
    check("basic_color", {16'b0, pixelColor}, 32'hFFFF);
    check("basic_valid", {31'b0, pixelValid}, 32'h1);

    // Inverse video
    pix("inv_bit1", 11'd5, 10'd2, 8'hC1, 3'd3, 3'd7, 1'b0, 1'b1, 16'h0000, 1'b1);
    pix("inv_bit0", 11'd5, 10'd2, 8'hC1, 3'd3, 3'd6, 1'b0, 1'b1, 16'hFFFF, 1'b1);

    // Foreground change waits for frame start
    foreGroundColor = 16'hF800;
    pix("fg_midframe", 11'd10, 10'd3, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    idle(1'b1);
    pix("fg_nextframe", 11'd10, 10'd3, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 16'hF800, 1'b1);

    // Background and textEnable
    backGroundColor = 16'h001F;
    idle(1'b1);
    pix("text_off", 11'd20, 10'd4, 8'h41, 3'd3, 3'd7, 1'b0, 1'b0, 16'h001F, 1'b1);
    pix("bg_pixel", 11'd20, 10'd4, 8'h41, 3'd3, 3'd6, 1'b0, 1'b1, 16'h001F, 1'b1);

    // Active area edges
    pix("last_px",   11'd1279, 10'd719, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 16'hF800, 1'b1);
    pix("past_px",   11'd1280, 10'd719, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 16'h0000, 1'b0);
    pix("past_line", 11'd1279, 10'd720, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 16'h0000, 1'b0);

    // Back-to-back stream across the line end and the last line
    for (int i = 0; i < 24; i++)
      step(11'(1270 + i), (i < 16) ? 10'd719 : 10'd720, 8'(i * 29), 3'(i), 3'(i * 3),
           (i % 5) == 0, (i % 7) != 3, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(11'(2044 + i), 10'd100, 8'(i * 53 + 7), 3'(i + 1), 3'(7 - i),
           (i % 2) == 1, 1'b1, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // Reset mid-line together with a frame pulse
    for (int i = 0; i < 4; i++)
      step(11'(100 + i), 10'd50, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step(11'd104, 10'd50, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(11'(105 + i), 10'd50, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      check("post_reset_invalid", {31'b0, pixelValid}, 32'h0);
    end
    step(11'd108, 10'd50, 8'h41, 3'd3, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    check("post_reset_valid", {31'b0, pixelValid}, 32'h1);
    check("post_reset_fg",    {16'b0, pixelColor}, 32'hFFFF);
    idle(1'b0); idle(1'b0); idle(1'b0);
    pix("reset_bg", 11'd0, 10'd0, 8'hC1, 3'd3, 3'd7, 1'b0, 1'b1, 16'h0000, 1'b1);

    // Cursor blink over six frames
    foreGroundColor = 16'hFFFF;
    backGroundColor = 16'h07E0;
    for (int k = 0; k < 6; k++) begin
      pix($sformatf("blink_f%0d", k), 11'd30, 10'd6, 8'h00, 3'd0, 3'd0, 1'b1, 1'b1,
          blink_exp[k], 1'b1);
      check($sformatf("noblink_f%0d", k), {16'b0, pixelColor0}, 32'hFFFF);
      idle(1'b1);
    end
    idle(1'b0); idle(1'b0); idle(1'b0);
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
